keypad_scan: RTL
================

# keypad_scan

Multiplexed 4x4 matrix keypad scanner: the input-side counterpart of the multiplexed 4-digit display driver. It drives keypad columns one-hot active-low, the same way digit anodes are strobed, and samples the active-low row lines. The block debounces the full key matrix and delivers one 4-bit key code per press over a valid/ack handshake. It sits between board I/O pins and the counter/display logic, clocked from the divided 0.5 MHz system clock.

## Interface
- SCAN_DIV, 2000: clock cycles each column is driven (4 ms at 0.5 MHz); minimum 4.
- DEBOUNCE_SCANS, 3: consecutive agreeing full-matrix frames required to accept a change; range 1..15.
- clk  in  1  system clock, one clock domain, all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- COL  out  4  column drive, active-low one-hot.
- ROW  in  4  row sense, active-low, externally pulled up, asynchronous to clk.
- key_ack  in  1  consumer acknowledge, sampled on rising edge.
- key_code  out  4  {col[1:0], row[1:0]} of accepted key.
- key_valid  out  1  new key event pending.
- key_down  out  1  level: an accepted key is currently held.
- overrun  out  1  sticky: press event lost because key_valid was still high.

## Operation
- ROW passes through a 2-flop synchronizer before any use.
- Scan: column index c (0..3) and slot divider d (0..SCAN_DIV-1). COL = ~(1<<c). On the edge where d==SCAN_DIV-1, store ~ROW_sync into frame bits [4c+3:4c], then d->0, c->c+1 mod 4.
- Frame end: the store with c==3. The 16-bit frame is classified as NONE (no bits set), SINGLE(code) (exactly one bit set, code=4c+r), or MULTI (two or more bits set).
- Debounce: compare the class against the previous class. If equal, agree count increments, saturating at DEBOUNCE_SCANS. If different, agree count is set to 1. The class becomes "stable" on the frame where agree count reaches DEBOUNCE_SCANS.
- FSM states: IDLE and PRESSED.
  - IDLE + stable SINGLE(k): go to PRESSED and raise a press event for k.
  - PRESSED + stable NONE: go to IDLE.
  - PRESSED + stable SINGLE of a different key: no effect. This is n-key lockout; release is required first.
  - MULTI in either state: no effect. MULTI still takes part in the agree counting.
- key_down = (state==PRESSED).
- Press event handling:
  - If key_valid==0: key_code<=k, key_valid<=1.
  - If key_valid==1 and key_ack is not high in the same cycle: key_code is unchanged and overrun<=1.
  - If key_valid==1 and key_ack is high in the same cycle: the old event is consumed, key_code<=k, key_valid stays 1, and overrun is not set.
- key_ack while key_valid==1 with no event clears key_valid next edge. key_ack while key_valid==0 is ignored.
- key_code is held constant while key_valid==1.
- overrun clears only on reset.

## Timing
- Reset values (asynchronous, immediate): COL=4'b1110, c=0, d=0, frame=0, previous class=NONE, agree count=0, state IDLE, key_code=0, key_valid=0, key_down=0, overrun=0.
- Reset asserted mid-scan returns COL to 4'b1110 without waiting for a clock. Scanning restarts from column 0, slot 0.
- ROW-to-sample latency: 2 cycles of synchronizer. A column is sampled at the end of its slot, which leaves SCAN_DIV-1 cycles of settling after the column switch.
- Frame period: 4*SCAN_DIV cycles.
- key_valid and key_down rise exactly 1 cycle after the frame-end edge that makes the class stable.
- key_down falls 1 cycle after the frame-end edge that makes NONE stable.
- Minimum press-to-event time: DEBOUNCE_SCANS full frames plus 1 cycle. With a press inside a frame, the partial frame may count if it already sampled the key.
- key_valid drops 1 cycle after the edge sampling key_ack high.

## Test plan
Parameters for the bench: SCAN_DIV=4, DEBOUNCE_SCANS=2, frame = 16 cycles.
- Reset mid-scan while COL=4'b1011 -> COL=4'b1110 immediately; all outputs 0; first COL change to 4'b1101 occurs 4 cycles after reset release.
- Hold row 2 low whenever COL=4'b1101 for 3 frames -> key_valid=1, key_code=4'd6, key_down=1. Pulse key_ack for 1 cycle -> key_valid=0 next cycle. Release for 2 frames -> key_down=0.
- Key 6 active for exactly one frame, then released -> key_valid and key_down stay 0 throughout.
- Press key 5 and let it be accepted without ack, release, then press key 9 and let it be accepted -> key_code stays 5, key_valid stays 1, overrun=1 and remains 1 after a later ack.
- Keys 0 and 15 held together for 4 frames from IDLE -> no key_valid and key_down=0. Release both, then hold key 3 -> event with key_code=3.
- Key_ack asserted on the exact cycle a new key 12 event is raised while key 5 is pending -> key_valid stays 1, key_code=12, overrun=0.

Source files
------------

// File: rtl/keypad_scan.sv
// keypad_scan -- multiplexed 4x4 matrix keypad scanner.
//
// Strobes the keypad columns one at a time, active-low. The row lines are
// sampled at the end of each column slot. A full 16-key frame is built up,
// classified, and debounced. One key code is delivered per accepted press
// over a valid/ack handshake.
//
// Ports:
//   clk        system clock; all state changes on the rising edge
//   reset      asynchronous, active-high reset
//   COL[3:0]   column drive, active-low one-hot
//   ROW[3:0]   row sense, active-low, asynchronous to clk
//   key_ack    consumer acknowledge for key_valid
//   key_code   {col[1:0], row[1:0]} of the accepted key
//   key_valid  a key event is pending
//   key_down   level: an accepted key is currently held
//   overrun    sticky: a press event was lost while key_valid was high
module keypad_scan #(
  parameter int SCAN_DIV       = 2000,
  parameter int DEBOUNCE_SCANS = 3
) (
  input  logic       clk,
  input  logic       reset,
  output logic [3:0] COL,
  input  logic [3:0] ROW,
  input  logic       key_ack,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_down,
  output logic       overrun
);

  localparam int             DW        = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DW-1:0]  DIV_LAST  = DW'(SCAN_DIV - 1);
  localparam logic [3:0]     AGREE_MAX = 4'(DEBOUNCE_SCANS);

  // Class encoding: {kind[1:0], code[3:0]}; code is zero unless kind is SINGLE,
  // so NONE and MULTI compare equal to themselves regardless of which keys.
  localparam logic [1:0] KIND_NONE   = 2'd0;
  localparam logic [1:0] KIND_SINGLE = 2'd1;
  localparam logic [1:0] KIND_MULTI  = 2'd2;

  typedef enum logic {IDLE, PRESSED} state_t;

  logic [3:0]    row_meta;
  logic [3:0]    row_sync;
  logic [1:0]    col_idx;
  logic [DW-1:0] div_cnt;
  logic [15:0]   frame;
  logic [15:0]   frame_now;
  logic          slot_end;
  logic          frame_end;
  logic [4:0]    ones;
  logic [3:0]    hit_idx;
  logic [5:0]    cls;
  logic [5:0]    prev_cls;
  logic [3:0]    agree_cnt;
  logic [3:0]    agree_next;
  logic          stable_now;
  logic          stable_pulse;
  logic [5:0]    stable_cls;
  state_t        state;
  state_t        state_next;
  logic          press_event;

  // Two-flop synchronizer on the row lines; idle rows read as released.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      row_meta <= 4'hF;
      row_sync <= 4'hF;
    end else begin
      row_meta <= ROW;
      row_sync <= row_meta;
    end
  end

  // Column/slot counters.
  assign slot_end  = (div_cnt == DIV_LAST);
  assign frame_end = slot_end && (col_idx == 2'd3);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt <= '0;
      col_idx <= 2'd0;
    end else if (slot_end) begin
      div_cnt <= '0;
      col_idx <= col_idx + 2'd1;
    end else begin
      div_cnt <= div_cnt + DW'(1);
    end
  end

  // Driven straight from the reset-cleared counter so reset lands on column 0
  // without waiting for a clock edge.
  assign COL = ~(4'b0001 << col_idx);

  // Frame storage, one nibble per column (bit set = key pressed).
  for (genvar gi = 0; gi < 4; gi++) begin : g_nibble
    always_ff @(posedge clk or posedge reset) begin
      if (reset)
        frame[4*gi +: 4] <= 4'h0;
      else if (slot_end && (col_idx == 2'(gi)))
        frame[4*gi +: 4] <= ~row_sync;
    end
  end

  // The frame as it will be after this edge; used at frame end so the last
  // column is classified together with the other three.
  always_comb begin
    frame_now = frame;
    frame_now[{col_idx, 2'b00} +: 4] = ~row_sync;
  end

  always_comb begin
    ones    = 5'd0;
    hit_idx = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (frame_now[i]) begin
        ones    = ones + 5'd1;
        hit_idx = 4'(i);
      end
    end
    if (ones == 5'd0)
      cls = {KIND_NONE, 4'd0};
    else if (ones == 5'd1)
      cls = {KIND_SINGLE, hit_idx};
    else
      cls = {KIND_MULTI, 4'd0};
  end

  // Debounce: the class is stable on the frame where the agree count first
  // reaches the limit; a saturated count does not re-announce it.
  always_comb begin
    if (cls == prev_cls)
      agree_next = (agree_cnt == AGREE_MAX) ? agree_cnt : agree_cnt + 4'd1;
    else
      agree_next = 4'd1;
    stable_now = (agree_next == AGREE_MAX) &&
                 ((cls != prev_cls) || (agree_cnt != AGREE_MAX));
  end

  // The stable decision is registered, so the FSM acts one cycle after the
  // frame-end edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_cls     <= {KIND_NONE, 4'd0};
      agree_cnt    <= 4'd0;
      stable_pulse <= 1'b0;
      stable_cls   <= {KIND_NONE, 4'd0};
    end else if (frame_end) begin
      prev_cls     <= cls;
      agree_cnt    <= agree_next;
      stable_pulse <= stable_now;
      stable_cls   <= cls;
    end else begin
      stable_pulse <= 1'b0;
    end
  end

  // FSM: state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_next;
  end

  // FSM: next state. A different single key while PRESSED is locked out,
  // and MULTI never moves the FSM.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:
        if (stable_pulse && (stable_cls[5:4] == KIND_SINGLE))
          state_next = PRESSED;
      PRESSED:
        if (stable_pulse && (stable_cls[5:4] == KIND_NONE))
          state_next = IDLE;
      default:
        state_next = IDLE;
    endcase
  end

  // FSM: outputs.
  always_comb begin
    press_event = (state == IDLE) && stable_pulse &&
                  (stable_cls[5:4] == KIND_SINGLE);
    key_down    = (state == PRESSED);
  end

  // Valid/ack handshake. An ack in the same cycle as a new event consumes
  // the old one, so the new code can replace it without an overrun.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      key_code  <= 4'd0;
      key_valid <= 1'b0;
      overrun   <= 1'b0;
    end else if (press_event) begin
      if (!key_valid || key_ack) begin
        key_code  <= stable_cls[3:0];
        key_valid <= 1'b1;
      end else begin
        overrun   <= 1'b1;
      end
    end else if (key_valid && key_ack) begin
      key_valid <= 1'b0;
    end
  end

endmodule
